// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory read channel,
// redirect input and decode-side valid/ready channel.
//   master: fetch unit side (drives imem_req/addr, instr_*)
//   slave : environment side (memory, branch unit, decode)
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem reads,
// PC-tagged instruction FIFO and redirect/flush handling.
//   clk, rst : clock, synchronous active-high reset
//   bus      : instr_fetch_unit_if.master (imem, redirect, decode)
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_unit_if.master bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DISCARD
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   buf_instr_q [FIFO_DEPTH];
    logic [31:0]   buf_pc_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] count_pushed;
    logic          push;
    logic          pop;
    logic          redir;

    assign redir = bus.redirect_valid;
    assign pop   = (count_q != '0) & bus.instr_ready;

    // Occupancy after this cycle's push and pop, used to
    // decide whether another fetch fits.
    assign count_pushed = count_q + CW'(1) - CW'(pop);

    assign bus.imem_req    = (state_q == REQ);
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = buf_instr_q[rd_ptr_q];
    assign bus.instr_pc    = buf_pc_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q < FULL) state_d = REQ;
            end
            REQ: begin
                if (bus.imem_gnt) begin
                    if (redir) begin
                        state_d = DISCARD;
                    end else begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (redir) begin
                    state_d = bus.imem_rvalid ? IDLE : DISCARD;
                end else if (bus.imem_rvalid) begin
                    push    = 1'b1;
                    state_d = (count_pushed < FULL) ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (bus.imem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (redir) fetch_pc_d = bus.redirect_pc & ~32'd3;
    end

    // A redirect flushes the buffer; a same-cycle pop has
    // already been seen by decode, so dropping it is safe.
    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
        if (redir) count_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_instr_q[i] <= '0;
                buf_pc_q[i]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            if (redir) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    buf_instr_q[wr_ptr_q] <= bus.imem_rdata;
                    buf_pc_q[wr_ptr_q]    <= req_pc_q;
                    wr_ptr_q <= (wr_ptr_q == LAST) ?
                                '0 : wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= (rd_ptr_q == LAST) ?
                                '0 : rd_ptr_q + PW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: memory responder plus
// stream-level model (consecutive PCs from each redirect).
module tb_instr_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .RESET_PC  (RPC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        int          ep;
    } obs_t;

    obs_t        obs_q[$];
    logic [31:0] start_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int gnt_pct, rdy_pct, spur_pct, lat_min, lat_max;
    logic        mem_pend;
    logic [31:0] mem_addr;
    int          mem_wait;
    logic        last_granted;
    int          viol_addr = 0;
    int          viol_out  = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic cycle();
        logic        granted, responded, redir, held, rst_was;
        logic [31:0] a;
        obs_t        o;
        rst_was   = rst;
        granted   = bus.imem_req && bus.imem_gnt && !rst;
        responded = bus.imem_rvalid && mem_pend;
        redir     = bus.redirect_valid && !rst;
        held      = bus.imem_req && !bus.imem_gnt && !redir && !rst;
        a         = bus.imem_addr;
        if (!rst && bus.instr_valid && bus.instr_ready) begin
            o.pc  = bus.instr_pc;
            o.ins = bus.instr;
            o.ep  = start_q.size() - 1;
            obs_q.push_back(o);
        end
        if (redir) start_q.push_back(bus.redirect_pc & ~32'd3);
        @(posedge clk);
        #1;
        last_granted = granted;
        if (rst_was || responded) mem_pend = 1'b0;
        if (granted) begin
            mem_pend = 1'b1;
            mem_addr = a;
            mem_wait = int'($urandom_range(lat_max, lat_min)) - 1;
        end else if (mem_pend && mem_wait > 0) begin
            mem_wait--;
        end
        if (held && bus.imem_req && bus.imem_addr !== a) viol_addr++;
        if (bus.imem_req && mem_pend) viol_out++;
        bus.imem_gnt = ($urandom_range(99, 0) < gnt_pct);
        bus.imem_rdata = $urandom;
        bus.imem_rvalid = 1'b0;
        if (mem_pend && mem_wait == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = memf(mem_addr);
        end else if (!mem_pend && $urandom_range(99, 0) < spur_pct) begin
            bus.imem_rvalid = 1'b1;
        end
        bus.instr_ready    = ($urandom_range(99, 0) < rdy_pct);
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_pend = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;
        start_q = {RPC};
        obs_q.delete();
    endtask

    task automatic cfg(input int g, input int r, input int lo,
                       input int hi, input int s);
        gnt_pct  = g;
        rdy_pct  = r;
        lat_min  = lo;
        lat_max  = hi;
        spur_pct = s;
    endtask

    task automatic test_reset();
        cfg(100, 100, 1, 1, 0);
        rst = 1'b1;
        mem_pend = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = 32'h0000_0500;
            n_checks++;
            if (bus.imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_req: got %b want 0", bus.imem_req);
            end
            n_checks++;
            if (bus.instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid: got %b want 0", bus.instr_valid);
            end
            n_checks++;
            if (bus.instr !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_instr: got %h want 0", bus.instr);
            end
            n_checks++;
            if (bus.instr_pc !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_pc: got %h want 0", bus.instr_pc);
            end
            n_checks++;
            if (bus.imem_addr !== RPC) begin
                n_fail++;
                $display("FAIL reset_addr: got %h want %h", bus.imem_addr, RPC);
            end
        end
        bus.redirect_valid = 1'b0;
        rst = 1'b0;
        start_q = {RPC};
        obs_q.delete();
        n_checks++;
        if (bus.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL release_idle: req got %b want 0", bus.imem_req);
        end
        cycle();
        n_checks++;
        if (bus.imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL first_req: got %b want 1", bus.imem_req);
        end
        n_checks++;
        if (bus.imem_addr !== RPC) begin
            n_fail++;
            $display("FAIL first_addr: got %h want %h", bus.imem_addr, RPC);
        end
    endtask

    task automatic test_latency();
        cfg(100, 100, 1, 1, 0);
        do_reset();
        cycle();
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL lat_req0: req %b addr %h want 1 0",
                     bus.imem_req, bus.imem_addr);
        end
        cycle();
        n_checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_wait: valid %b req %b want 0 0",
                     bus.instr_valid, bus.imem_req);
        end
        cycle();
        n_checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0050_0093 ||
            bus.instr_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL lat_first: v %b %h @%h want 1 00500093 @0",
                     bus.instr_valid, bus.instr, bus.instr_pc);
        end
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL lat_req1: req %b addr %h want 1 4",
                     bus.imem_req, bus.imem_addr);
        end
        cycle();
        n_checks++;
        if (bus.instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_gap: valid %b want 0", bus.instr_valid);
        end
        cycle();
        n_checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h00A0_0113 ||
            bus.instr_pc !== 32'h4) begin
            n_fail++;
            $display("FAIL lat_second: v %b %h @%h want 1 00a00113 @4",
                     bus.instr_valid, bus.instr, bus.instr_pc);
        end
    endtask

    task automatic test_backpressure();
        int grants;
        int n;
        cfg(100, 0, 1, 1, 0);
        do_reset();
        grants = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (last_granted) grants++;
        end
        n_checks++;
        if (grants != DEPTH) begin
            n_fail++;
            $display("FAIL bp_grants: got %0d want %0d", grants, DEPTH);
        end
        n_checks++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: req %b valid %b want 0 1",
                     bus.imem_req, bus.instr_valid);
        end
        n_checks++;
        if (bus.instr_pc !== 32'h0 || bus.instr !== memf(32'h0)) begin
            n_fail++;
            $display("FAIL bp_head: %h @%h want %h @0",
                     bus.instr, bus.instr_pc, memf(32'h0));
        end
        rdy_pct = 100;
        bus.instr_ready = 1'b1;
        n = 0;
        while (obs_q.size() < 3 && n < 40) begin
            cycle();
            n++;
        end
        n_checks++;
        if (obs_q.size() < 3) begin
            n_fail++;
            $display("FAIL bp_timeout: got %0d instrs want 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_q[i].pc !== 32'(4 * i) ||
                    obs_q[i].ins !== memf(32'(4 * i))) begin
                    n_fail++;
                    $display("FAIL bp_order%0d: %h @%h want %h @%h", i,
                             obs_q[i].ins, obs_q[i].pc,
                             memf(32'(4 * i)), 4 * i);
                end
            end
        end
    endtask

    task automatic test_redirect_wait();
        int n;
        cfg(100, 0, 2, 2, 0);
        do_reset();
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(last_granted && bus.instr_valid) && n < 30);
        n_checks++;
        if (!(last_granted && bus.instr_valid)) begin
            n_fail++;
            $display("FAIL rw_setup: no WAIT with buffered instr, got 0 want 1");
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        cycle();
        n_checks++;
        if (bus.instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_flush: valid %b want 0", bus.instr_valid);
        end
        n = 0;
        while (!bus.imem_req && n < 10) begin
            cycle();
            n++;
        end
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL rw_addr: req %b addr %h want 1 100",
                     bus.imem_req, bus.imem_addr);
        end
        rdy_pct = 100;
        bus.instr_ready = 1'b1;
        n = 0;
        while (obs_q.size() == 0 && n < 20) begin
            cycle();
            n++;
        end
        n_checks++;
        if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL rw_timeout: got 0 instrs want 1");
        end else if (obs_q[0].pc !== 32'h100 ||
                     obs_q[0].ins !== memf(32'h100)) begin
            n_fail++;
            $display("FAIL rw_first: %h @%h want %h @100",
                     obs_q[0].ins, obs_q[0].pc, memf(32'h100));
        end
    endtask

    task automatic test_redirect_gnt_rvalid();
        int          n;
        int          e;
        int          k;
        logic [31:0] ra;
        cfg(100, 100, 1, 1, 0);
        do_reset();
        n = 0;
        while (!(bus.imem_req && bus.imem_gnt) && n < 20) begin
            cycle();
            n++;
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        e = start_q.size();
        k = -1;
        n = 0;
        while (k < 0 && n < 40) begin
            cycle();
            n++;
            foreach (obs_q[i]) if (k < 0 && obs_q[i].ep == e) k = i;
        end
        n_checks++;
        if (k < 0) begin
            n_fail++;
            $display("FAIL rg_timeout: got no instr want pc 200");
        end else if (obs_q[k].pc !== 32'h200) begin
            n_fail++;
            $display("FAIL rg_first: pc %h want 200", obs_q[k].pc);
        end
        n = 0;
        while (!bus.imem_rvalid && n < 20) begin
            cycle();
            n++;
        end
        ra = mem_addr;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0301;
        e = start_q.size();
        k = -1;
        n = 0;
        while (k < 0 && n < 40) begin
            cycle();
            n++;
            foreach (obs_q[i]) if (k < 0 && obs_q[i].ep == e) k = i;
        end
        n_checks++;
        if (k < 0) begin
            n_fail++;
            $display("FAIL rr_timeout: got no instr want pc 300");
        end else if (obs_q[k].pc !== 32'h300) begin
            n_fail++;
            $display("FAIL rr_first: pc %h want 300", obs_q[k].pc);
        end
        n = 0;
        foreach (obs_q[i]) if (obs_q[i].pc == ra) n++;
        n_checks++;
        if (n != 0) begin
            n_fail++;
            $display("FAIL rr_dropped: pc %h seen %0d times want 0", ra, n);
        end
    endtask

    task automatic test_wrap();
        int n;
        int k0;
        int e;
        cfg(100, 100, 1, 1, 0);
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        e = start_q.size();
        k0 = -1;
        n = 0;
        while (n < 40) begin
            cycle();
            n++;
            k0 = -1;
            foreach (obs_q[i]) if (k0 < 0 && obs_q[i].ep == e) k0 = i;
            if (k0 >= 0 && obs_q.size() >= k0 + 2) break;
        end
        n_checks++;
        if (k0 < 0 || obs_q.size() < k0 + 2) begin
            n_fail++;
            $display("FAIL wrap_timeout: got fewer than 2 instrs want 2");
        end else begin
            n_checks++;
            if (obs_q[k0].pc !== 32'hFFFF_FFFC ||
                obs_q[k0].ins !== memf(32'hFFFF_FFFC)) begin
                n_fail++;
                $display("FAIL wrap_top: %h @%h want %h @fffffffc",
                         obs_q[k0].ins, obs_q[k0].pc, memf(32'hFFFF_FFFC));
            end
            n_checks++;
            if (obs_q[k0+1].pc !== 32'h0 ||
                obs_q[k0+1].ins !== memf(32'h0)) begin
                n_fail++;
                $display("FAIL wrap_zero: %h @%h want %h @0",
                         obs_q[k0+1].ins, obs_q[k0+1].pc, memf(32'h0));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] expc;
        logic [31:0] p;
        int          lastep;
        cfg(60, 60, 1, 3, 20);
        do_reset();
        viol_addr = 0;
        viol_out  = 0;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if ($urandom_range(99, 0) < 4) begin
                p = $urandom;
                if ($urandom_range(3, 0) == 0)
                    p = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = p;
            end
        end
        expc   = '0;
        lastep = -1;
        foreach (obs_q[i]) begin
            if (obs_q[i].ep != lastep) expc = start_q[obs_q[i].ep];
            n_checks++;
            if (obs_q[i].pc !== expc) begin
                n_fail++;
                $display("FAIL rnd_pc[%0d]: got %h want %h",
                         i, obs_q[i].pc, expc);
            end
            n_checks++;
            if (obs_q[i].ins !== memf(expc)) begin
                n_fail++;
                $display("FAIL rnd_ins[%0d]: got %h want %h",
                         i, obs_q[i].ins, memf(expc));
            end
            expc   = expc + 32'd4;
            lastep = obs_q[i].ep;
        end
        n_checks++;
        if (obs_q.size() < 100) begin
            n_fail++;
            $display("FAIL rnd_progress: got %0d instrs want >=100",
                     obs_q.size());
        end
        n_checks++;
        if (viol_addr != 0) begin
            n_fail++;
            $display("FAIL rnd_addr_stable: got %0d changes want 0", viol_addr);
        end
        n_checks++;
        if (viol_out != 0) begin
            n_fail++;
            $display("FAIL rnd_outstanding: got %0d want 0", viol_out);
        end
    endtask

    initial begin
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
        mem_pend     = 1'b0;
        mem_addr     = '0;
        mem_wait     = 0;
        last_granted = 1'b0;
        start_q      = {RPC};
        test_reset();
        test_latency();
        test_backpressure();
        test_redirect_wait();
        test_redirect_gnt_rvalid();
        test_wrap();
        test_random();
        test_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
